// File: rtl/pe_acc_pkg.sv
// Shared types and helpers for the PE accumulator: FSM encoding and
// accumulator clamp values derived from the accumulator width.
package pe_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } acc_state_e;

    // Clamp values returned as 64-bit patterns; callers size-cast them to their width.
    function automatic logic [63:0] acc_smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_smin(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] acc_umax(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pe_acc_lane.sv
// One accumulator lane: extend, add, overflow detect, saturate or wrap,
// plus the accumulator register and its sticky overflow flag.
module pe_acc_lane
    import pe_acc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  load,
    input  logic [ACC_WIDTH-1:0]  load_val,
    input  logic                  add_en,
    input  logic                  is_signed,
    input  logic                  sat_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  ovf
);

    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(acc_smax(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(acc_smin(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'(acc_umax(ACC_WIDTH));

    logic [ACC_WIDTH-1:0] acc_r;
    logic                 ovf_r;
    logic [EXT_W-1:0]     addend_s;
    logic [EXT_W-1:0]     acc_ext_s;
    logic [EXT_W-1:0]     sum_s;
    logic                 ovf_s;
    logic [ACC_WIDTH-1:0] next_s;

    // Extend both operands one bit past the accumulator, add, and clamp or wrap.
    always_comb begin
        addend_s  = {{(EXT_W - DATA_WIDTH){data[DATA_WIDTH-1] & is_signed}}, data};
        acc_ext_s = {acc_r[ACC_WIDTH-1] & is_signed, acc_r};
        sum_s     = acc_ext_s + addend_s;
        if (is_signed) begin
            ovf_s = sum_s[EXT_W-1] ^ sum_s[ACC_WIDTH-1];
        end else begin
            ovf_s = sum_s[EXT_W-1];
        end
        if (ovf_s && sat_en) begin
            if (!is_signed) begin
                next_s = UMAX;
            end else if (sum_s[EXT_W-1]) begin
                next_s = SMIN;
            end else begin
                next_s = SMAX;
            end
        end else begin
            next_s = sum_s[ACC_WIDTH-1:0];
        end
    end

    // Accumulator and sticky overflow; a load starts a fresh tile.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (load) begin
            acc_r <= load_val;
            ovf_r <= 1'b0;
        end else if (add_en) begin
            acc_r <= next_s;
            ovf_r <= ovf_r | ovf_s;
        end
    end

    assign acc = acc_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/pe_acc_stream.sv
// Multi-lane PE accumulator: sums a programmed number of beats per tile and
// drains the registered result through a valid/ready handshake.
module pe_acc_stream
    import pe_acc_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int DATA_COPIES = 32,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [LEN_WIDTH-1:0]              i_len,
    input  logic                              i_signed,
    input  logic                              i_sat_en,
    input  logic                              i_bias_en,
    input  logic [DATA_COPIES*ACC_WIDTH-1:0]  i_bias,
    input  logic [DATA_COPIES*DATA_WIDTH-1:0] i_mdata,
    input  logic                              i_mdata_vld,
    output logic                              o_mdata_rdy,
    output logic [DATA_COPIES*ACC_WIDTH-1:0]  o_acc_result,
    output logic                              o_acc_vld,
    input  logic                              i_acc_rdy,
    output logic [DATA_COPIES-1:0]            o_ovf,
    output logic                              o_busy
);

    acc_state_e           state_r, state_nx_s;
    logic [LEN_WIDTH-1:0] cnt_r;
    logic                 signed_r, sat_en_r;
    logic                 rdy_r, vld_r, busy_r;
    logic                 rdy_nx_s, vld_nx_s, busy_nx_s;
    logic                 load_s, beat_s;

    // A start is honoured from IDLE, or from OUT in the cycle the result drains.
    assign load_s = i_start & ((state_r == ST_IDLE) | ((state_r == ST_OUT) & i_acc_rdy));
    assign beat_s = i_mdata_vld & rdy_r;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nx_s = (i_len != {LEN_WIDTH{1'b0}}) ? ST_ACC : ST_OUT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (beat_s && (cnt_r == LEN_WIDTH'(1))) begin
                    state_nx_s = ST_OUT;
                end else begin
                    state_nx_s = ST_ACC;
                end
            end
            ST_OUT: begin
                if (i_acc_rdy && i_start) begin
                    state_nx_s = (i_len != {LEN_WIDTH{1'b0}}) ? ST_ACC : ST_OUT;
                end else if (i_acc_rdy) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flops line up with state_r.
    always_comb begin
        rdy_nx_s  = 1'b0;
        vld_nx_s  = 1'b0;
        busy_nx_s = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin
                rdy_nx_s  = 1'b0;
                vld_nx_s  = 1'b0;
                busy_nx_s = 1'b0;
            end
            ST_ACC: begin
                rdy_nx_s  = 1'b1;
                busy_nx_s = 1'b1;
            end
            ST_OUT: begin
                vld_nx_s  = 1'b1;
                busy_nx_s = 1'b1;
            end
            default: begin
                rdy_nx_s  = 1'b0;
                vld_nx_s  = 1'b0;
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_r  <= 1'b0;
            vld_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            rdy_r  <= rdy_nx_s;
            vld_r  <= vld_nx_s;
            busy_r <= busy_nx_s;
        end
    end

    // Tile configuration and remaining-beat counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r    <= {LEN_WIDTH{1'b0}};
            signed_r <= 1'b0;
            sat_en_r <= 1'b0;
        end else if (load_s) begin
            cnt_r    <= i_len;
            signed_r <= i_signed;
            sat_en_r <= i_sat_en;
        end else if (beat_s) begin
            cnt_r    <= cnt_r - LEN_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
        pe_acc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .load      (load_s),
            .load_val  (i_bias_en ? i_bias[ACC_WIDTH*g +: ACC_WIDTH] : {ACC_WIDTH{1'b0}}),
            .add_en    (beat_s),
            .is_signed (signed_r),
            .sat_en    (sat_en_r),
            .data      (i_mdata[DATA_WIDTH*g +: DATA_WIDTH]),
            .acc       (o_acc_result[ACC_WIDTH*g +: ACC_WIDTH]),
            .ovf       (o_ovf[g])
        );
    end

    assign o_mdata_rdy = rdy_r;
    assign o_acc_vld   = vld_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_pe_acc_stream.sv
// Directed self-checking bench for pe_acc_stream with 2 lanes of 8-bit data
// into 10-bit accumulators.
module tb_pe_acc_stream;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int DC = 2;
    localparam int LW = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_start, i_signed, i_sat_en, i_bias_en, i_mdata_vld, i_acc_rdy;
    logic [LW-1:0]     i_len;
    logic [DC*AW-1:0]  i_bias;
    logic [DC*DW-1:0]  i_mdata;
    logic              o_mdata_rdy, o_acc_vld, o_busy;
    logic [DC*AW-1:0]  o_acc_result;
    logic [DC-1:0]     o_ovf;
    int                checks = 0;
    int                errors = 0;

    pe_acc_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .DATA_COPIES(DC), .LEN_WIDTH(LW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
        .i_signed(i_signed), .i_sat_en(i_sat_en), .i_bias_en(i_bias_en), .i_bias(i_bias),
        .i_mdata(i_mdata), .i_mdata_vld(i_mdata_vld), .o_mdata_rdy(o_mdata_rdy),
        .o_acc_result(o_acc_result), .o_acc_vld(o_acc_vld), .i_acc_rdy(i_acc_rdy),
        .o_ovf(o_ovf), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_tile(input logic [LW-1:0] len, input logic sgn, input logic sat,
                              input logic ben, input logic [AW-1:0] b0, input logic [AW-1:0] b1);
        i_start = 1'b1; i_len = len; i_signed = sgn; i_sat_en = sat;
        i_bias_en = ben; i_bias = {b1, b0};
        tick();
        i_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        i_mdata = {d1, d0}; i_mdata_vld = 1'b1;
        tick();
        i_mdata_vld = 1'b0;
    endtask

    task automatic drain();
        i_acc_rdy = 1'b1;
        tick();
        i_acc_rdy = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_signed = 1'b0; i_sat_en = 1'b0;
        i_bias_en = 1'b0; i_bias = '0; i_mdata = '0; i_mdata_vld = 1'b0; i_acc_rdy = 1'b0;
        tick(); tick();
        checks++;
        if ({o_acc_vld, o_mdata_rdy, o_busy, o_ovf, o_acc_result} !== {(DC*AW+DC+3){1'b0}}) begin
            errors++;
            $display("FAIL reset_state got vld=%b rdy=%b busy=%b ovf=%b res=%h exp all zero",
                     o_acc_vld, o_mdata_rdy, o_busy, o_ovf, o_acc_result);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_signed_basic();
        start_tile(16'd4, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        checks++;
        if (o_mdata_rdy !== 1'b1 || o_busy !== 1'b1) begin
            errors++; $display("FAIL t1_acc_state got rdy=%b busy=%b exp 1 1", o_mdata_rdy, o_busy);
        end
        beat(8'h03, 8'h01); beat(8'hFB, 8'h01); beat(8'h7F, 8'h01);
        checks++;
        if (o_acc_vld !== 1'b0) begin
            errors++; $display("FAIL t1_early_vld got %b exp 0", o_acc_vld);
        end
        beat(8'h80, 8'h01);
        checks++;
        if (o_acc_vld !== 1'b1 || o_mdata_rdy !== 1'b0) begin
            errors++; $display("FAIL t1_vld got vld=%b rdy=%b exp 1 0", o_acc_vld, o_mdata_rdy);
        end
        checks++;
        if (o_acc_result !== {10'd4, 10'h3FD} || o_ovf !== 2'b00) begin
            errors++; $display("FAIL t1_result got %h ovf=%b exp %h ovf=00", o_acc_result, o_ovf, {10'd4, 10'h3FD});
        end
        drain();
        checks++;
        if (o_acc_vld !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL t1_drain got vld=%b busy=%b exp 0 0", o_acc_vld, o_busy);
        end
    endtask

    task automatic test_signed_sat();
        for (int s = 1; s >= 0; s--) begin
            start_tile(16'd5, 1'b1, s[0], 1'b0, 10'd0, 10'd0);
            for (int k = 0; k < 5; k++) beat(8'h7F, 8'h00);
            checks++;
            if (o_acc_result !== {10'd0, (s == 1) ? 10'h1FF : 10'h27B} || o_ovf !== 2'b01) begin
                errors++; $display("FAIL t2_sat%0d got %h ovf=%b exp %h ovf=01", s, o_acc_result, o_ovf,
                                   {10'd0, (s == 1) ? 10'h1FF : 10'h27B});
            end
            drain();
        end
    endtask

    task automatic test_unsigned_sat();
        for (int s = 1; s >= 0; s--) begin
            start_tile(16'd5, 1'b0, s[0], 1'b0, 10'd0, 10'd0);
            for (int k = 0; k < 5; k++) beat(8'hFF, 8'h00);
            checks++;
            if (o_acc_result !== {10'd0, (s == 1) ? 10'h3FF : 10'd251} || o_ovf !== 2'b01) begin
                errors++; $display("FAIL t3_usat%0d got %h ovf=%b exp %h ovf=01", s, o_acc_result, o_ovf,
                                   {10'd0, (s == 1) ? 10'h3FF : 10'd251});
            end
            drain();
        end
    endtask

    task automatic test_bias_len0();
        start_tile(16'd0, 1'b1, 1'b0, 1'b1, 10'h39C, 10'd7);
        checks++;
        if (o_acc_vld !== 1'b1 || o_mdata_rdy !== 1'b0) begin
            errors++; $display("FAIL t4_len0_vld got vld=%b rdy=%b exp 1 0", o_acc_vld, o_mdata_rdy);
        end
        checks++;
        if (o_acc_result !== {10'd7, 10'h39C}) begin
            errors++; $display("FAIL t4_bias got %h exp %h", o_acc_result, {10'd7, 10'h39C});
        end
        drain();
    endtask

    task automatic test_back_to_back();
        // Lane1 starts at 500 and saturates at 511 on its third beat.
        start_tile(16'd3, 1'b1, 1'b1, 1'b1, 10'd0, 10'd500);
        beat(8'd10, 8'd5);
        for (int k = 0; k < 2; k++) tick();
        beat(8'd20, 8'd5);
        tick(); tick();
        checks++;
        if (o_acc_vld !== 1'b0 || o_busy !== 1'b1 || o_mdata_rdy !== 1'b1) begin
            errors++; $display("FAIL t5_bubble got vld=%b busy=%b rdy=%b exp 0 1 1", o_acc_vld, o_busy, o_mdata_rdy);
        end
        beat(8'd30, 8'd5);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_acc_vld !== 1'b1 || o_acc_result !== {10'h1FF, 10'd60} || o_ovf !== 2'b10) begin
                errors++; $display("FAIL t5_hold%0d got vld=%b %h ovf=%b exp 1 %h ovf=10", k, o_acc_vld,
                                   o_acc_result, o_ovf, {10'h1FF, 10'd60});
            end
            tick();
        end
        i_acc_rdy = 1'b1;
        start_tile(16'd2, 1'b1, 1'b0, 1'b1, 10'd5, 10'd0);
        i_acc_rdy = 1'b0;
        checks++;
        if (o_acc_vld !== 1'b0 || o_mdata_rdy !== 1'b1 || o_acc_result !== {10'd0, 10'd5} || o_ovf !== 2'b00) begin
            errors++; $display("FAIL t5_b2b_load got vld=%b rdy=%b %h ovf=%b exp 0 1 %h 00", o_acc_vld,
                               o_mdata_rdy, o_acc_result, o_ovf, {10'd0, 10'd5});
        end
        beat(8'd1, 8'd1); beat(8'd2, 8'd2);
        checks++;
        if (o_acc_vld !== 1'b1 || o_acc_result !== {10'd3, 10'd8}) begin
            errors++; $display("FAIL t5_b2b_result got vld=%b %h exp 1 %h", o_acc_vld, o_acc_result, {10'd3, 10'd8});
        end
        drain();
    endtask

    task automatic test_reset_mid_tile();
        start_tile(16'd4, 1'b0, 1'b0, 1'b1, 10'd9, 10'd9);
        beat(8'd100, 8'd100); beat(8'd100, 8'd100);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_acc_vld, o_mdata_rdy, o_busy, o_ovf, o_acc_result} !== {(DC*AW+DC+3){1'b0}}) begin
            errors++; $display("FAIL t6_async_reset got vld=%b rdy=%b busy=%b ovf=%b res=%h exp all zero",
                               o_acc_vld, o_mdata_rdy, o_busy, o_ovf, o_acc_result);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        start_tile(16'd2, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        beat(8'd1, 8'd0); beat(8'd1, 8'd0);
        checks++;
        if (o_acc_vld !== 1'b1 || o_acc_result !== {10'd0, 10'd2} || o_ovf !== 2'b00) begin
            errors++; $display("FAIL t6_after_reset got vld=%b %h ovf=%b exp 1 %h 00", o_acc_vld,
                               o_acc_result, o_ovf, {10'd0, 10'd2});
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_signed_sat();
        test_unsigned_sat();
        test_bias_len0();
        test_back_to_back();
        test_reset_mid_tile();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
